// File: rtl/tmds_encoder_multi_if.sv
// Stream bundle between a pixel/packet source and the multi-channel TMDS encoder.
// in_valid marks a word to encode. There is no backpressure: the encoder accepts every
// word. out_valid is high for one cycle per accepted word, exactly two cycles later.
interface tmds_encoder_multi_if #(
    parameter int NUM_CH = 3,
    parameter int DISP_W = 5
);
    logic                       in_valid;
    logic [1:0]                 mode;
    logic [2*NUM_CH-1:0]        ctrl;
    logic [8*NUM_CH-1:0]        video;
    logic [4*NUM_CH-1:0]        terc4;
    logic                       out_valid;
    logic [10*NUM_CH-1:0]       out_sym;
    logic [DISP_W*NUM_CH-1:0]   disparity;

    modport master (
        output in_valid, mode, ctrl, video, terc4,
        input  out_valid, out_sym, disparity
    );

    modport slave (
        input  in_valid, mode, ctrl, video, terc4,
        output out_valid, out_sym, disparity
    );
endinterface

// File: rtl/tmds_encoder_multi.sv
// Two-stage TMDS encoder for NUM_CH (1..4) parallel channels: control, video (8b/10b with
// running disparity of DISP_W (5..8) bits), TERC4 data island and video guard band.
module tmds_encoder_multi #(
    parameter int NUM_CH = 3,
    parameter int DISP_W = 5
) (
    input logic                 clk,
    input logic                 rst,
    tmds_encoder_multi_if.slave bus
);

    localparam logic [9:0] CTRL_00    = 10'b1101010100;
    localparam logic [9:0] CTRL_01    = 10'b0010101011;
    localparam logic [9:0] CTRL_10    = 10'b0101010100;
    localparam logic [9:0] CTRL_11    = 10'b1010101011;
    localparam logic [9:0] GUARD_EVEN = 10'b1011001100;
    localparam logic [9:0] GUARD_ODD  = 10'b0100110011;

    localparam logic signed [DISP_W-1:0] ZERO = '0;
    localparam logic signed [DISP_W-1:0] TWO  = DISP_W'(2);
    localparam logic signed [DISP_W-1:0] EIGHT = DISP_W'(8);

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

    // Transition-minimising stage: bit 8 records XOR (1) or XNOR (0) chaining.
    function automatic logic [8:0] qm_encode(input logic [7:0] d);
        logic [3:0] n;
        logic       use_xnor;
        logic [8:0] q;
        n        = ones8(d);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_token(input logic [3:0] t);
        logic [9:0] s;
        case (t)
            4'b0000: s = 10'b1010011100;
            4'b0001: s = 10'b1001100011;
            4'b0010: s = 10'b1011100100;
            4'b0011: s = 10'b1011100010;
            4'b0100: s = 10'b0101110001;
            4'b0101: s = 10'b0100011110;
            4'b0110: s = 10'b0110001110;
            4'b0111: s = 10'b0100111100;
            4'b1000: s = 10'b1011001100;
            4'b1001: s = 10'b0100111001;
            4'b1010: s = 10'b0110011100;
            4'b1011: s = 10'b1011000110;
            4'b1100: s = 10'b1010001110;
            4'b1101: s = 10'b1001110001;
            4'b1110: s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    logic                r_s1_valid;
    logic [1:0]          r_s1_mode;
    logic [2*NUM_CH-1:0] r_s1_ctrl;
    logic [4*NUM_CH-1:0] r_s1_terc4;
    logic                r_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= 2'b00;
            r_s1_ctrl   <= '0;
            r_s1_terc4  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_s1_valid  <= bus.in_valid;
            r_s1_mode   <= bus.mode;
            r_s1_ctrl   <= bus.ctrl;
            r_s1_terc4  <= bus.terc4;
            r_out_valid <= r_s1_valid;
        end
    end

    assign bus.out_valid = r_out_valid;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [8:0]               w_qm;
        logic [3:0]               w_qm_n1;
        logic [8:0]               r_qm;
        logic [3:0]               r_n1;
        logic [9:0]               r_sym;
        logic [9:0]               w_sym;
        logic signed [DISP_W-1:0] r_cnt;
        logic signed [DISP_W-1:0] w_cnt;
        logic signed [DISP_W-1:0] w_n1;
        logic signed [DISP_W-1:0] w_diff;
        logic                     w_cnt_zero;
        logic                     w_cnt_neg;
        logic                     w_cnt_pos;

        assign w_qm    = qm_encode(bus.video[8*k +: 8]);
        assign w_qm_n1 = ones8(w_qm[7:0]);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_qm <= '0;
                r_n1 <= '0;
            end else begin
                r_qm <= w_qm;
                r_n1 <= w_qm_n1;
            end
        end

        // w_diff is N1-N0 of q_m[7:0]; N1 vs N0 compares reduce to N1 vs 4.
        assign w_n1       = {{(DISP_W-4){1'b0}}, r_n1};
        assign w_diff     = w_n1 - (EIGHT - w_n1);
        assign w_cnt_zero = (r_cnt == ZERO);
        assign w_cnt_neg  = r_cnt[DISP_W-1];
        assign w_cnt_pos  = !w_cnt_neg && !w_cnt_zero;

        always_comb begin
            w_sym = r_sym;
            w_cnt = r_cnt;
            if (r_s1_valid) begin
                case (r_s1_mode)
                    2'b01: begin
                        if (w_cnt_zero || (r_n1 == 4'd4)) begin
                            w_sym = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                            w_cnt = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
                        end else if ((w_cnt_pos && (r_n1 > 4'd4)) ||
                                     (w_cnt_neg && (r_n1 < 4'd4))) begin
                            w_sym = {1'b1, r_qm[8], ~r_qm[7:0]};
                            w_cnt = r_cnt - w_diff + (r_qm[8] ? TWO : ZERO);
                        end else begin
                            w_sym = {1'b0, r_qm[8], r_qm[7:0]};
                            w_cnt = r_cnt + w_diff - (r_qm[8] ? ZERO : TWO);
                        end
                    end
                    2'b00: begin
                        w_sym = ctrl_token(r_s1_ctrl[2*k +: 2]);
                        w_cnt = ZERO;
                    end
                    2'b10: begin
                        w_sym = terc4_token(r_s1_terc4[4*k +: 4]);
                        w_cnt = ZERO;
                    end
                    default: begin
                        w_sym = ((k % 2) == 0) ? GUARD_EVEN : GUARD_ODD;
                        w_cnt = ZERO;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sym <= CTRL_00;
                r_cnt <= ZERO;
            end else begin
                r_sym <= w_sym;
                r_cnt <= w_cnt;
            end
        end

        assign bus.out_sym[10*k +: 10]          = r_sym;
        assign bus.disparity[DISP_W*k +: DISP_W] = r_cnt;
    end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Directed and decode-checked stimulus for the three-channel TMDS encoder.
module tb_tmds_encoder_multi;
  localparam int NUM_CH = 3;
  localparam int DISP_W = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tmds_encoder_multi_if #(.NUM_CH(NUM_CH), .DISP_W(DISP_W)) bus_if ();

  tmds_encoder_multi #(.NUM_CH(NUM_CH), .DISP_W(DISP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [8*NUM_CH-1:0] exp_q[$];
  int cnt_m[NUM_CH];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [1:0] m, input logic [5:0] c,
                       input logic [23:0] vid, input logic [11:0] t);
    bus_if.in_valid = v;
    bus_if.mode     = m;
    bus_if.ctrl     = c;
    bus_if.video    = vid;
    bus_if.terc4    = t;
  endtask

  task automatic idle();
    drive(1'b0, 2'b01, 6'd0, 24'd0, 12'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] sym(input int k);
    return bus_if.out_sym[10*k +: 10];
  endfunction

  function automatic int cnt_of(input int k);
    logic signed [DISP_W-1:0] t;
    t = bus_if.disparity[DISP_W*k +: DISP_W];
    return int'(t);
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // scoreboard
  task automatic score();
    logic [8*NUM_CH-1:0]      exp_w;
    logic [8*NUM_CH-1:0]      got_w;
    logic [DISP_W*NUM_CH-1:0] disp_m;
    logic                     in_bound;
    check_eq("queue_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      exp_w    = exp_q.pop_front();
      in_bound = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        got_w[8*k +: 8] = tmds_decode(sym(k));
        cnt_m[k] += 2 * $countones(sym(k)) - 10;
        disp_m[DISP_W*k +: DISP_W] = DISP_W'(cnt_m[k]);
        if (cnt_of(k) > 10 || cnt_of(k) < -10) in_bound = 1'b0;
      end
      check_eq("rand_decode", got_w, exp_w);
      check_eq("rand_disp", bus_if.disparity, disp_m);
      check_eq("rand_bound", in_bound, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) step();
    check_eq("rst_valid", bus_if.out_valid, 1'b0);
    check_eq("rst_sym", bus_if.out_sym, {3{10'b1101010100}});
    check_eq("rst_disp", bus_if.disparity, 15'd0);
    rst = 1'b0;

    // two video words: ch0/ch2 = 0x00, ch1 = 0xFF
    drive(1'b1, 2'b01, 6'd0, {8'h00, 8'hFF, 8'h00}, 12'd0);
    step();
    check_eq("lat_first", bus_if.out_valid, 1'b0);
    step();
    idle();
    check_eq("v1_valid", bus_if.out_valid, 1'b1);
    check_eq("v1_sym", bus_if.out_sym, {10'b0100000000, 10'b1000000000, 10'b0100000000});
    check_eq("v1_cnt0", cnt_of(0), -8);
    check_eq("v1_cnt1", cnt_of(1), -8);
    step();
    check_eq("v2_sym", bus_if.out_sym, {10'b1111111111, 10'b0011111111, 10'b1111111111});
    check_eq("v2_cnt0", cnt_of(0), 2);
    check_eq("v2_cnt1", cnt_of(1), -2);
    step();
    check_eq("bub_valid", bus_if.out_valid, 1'b0);
    check_eq("bub_sym0", sym(0), 10'b1111111111);
    check_eq("bub_cnt0", cnt_of(0), 2);
    check_eq("bub_cnt1", cnt_of(1), -2);

    // control word followed directly by video
    drive(1'b1, 2'b00, {2'b11, 2'b10, 2'b01}, 24'd0, 12'd0);
    step();
    drive(1'b1, 2'b01, 6'd0, 24'd0, 12'd0);
    step();
    idle();
    check_eq("ctl_valid", bus_if.out_valid, 1'b1);
    check_eq("ctl_sym", bus_if.out_sym, {10'b1010101011, 10'b0101010100, 10'b0010101011});
    check_eq("ctl_disp", bus_if.disparity, 15'd0);
    step();
    check_eq("ctl_next_valid", bus_if.out_valid, 1'b1);
    check_eq("ctl_next_sym0", sym(0), 10'b0100000000);
    check_eq("ctl_next_cnt0", cnt_of(0), -8);

    // guard band followed directly by video
    drive(1'b1, 2'b11, 6'd0, 24'd0, 12'd0);
    step();
    drive(1'b1, 2'b01, 6'd0, 24'd0, 12'd0);
    step();
    idle();
    check_eq("gb_sym", bus_if.out_sym, {10'b1011001100, 10'b0100110011, 10'b1011001100});
    check_eq("gb_disp", bus_if.disparity, 15'd0);
    step();
    check_eq("gb_next_sym0", sym(0), 10'b0100000000);
    check_eq("gb_next_cnt0", cnt_of(0), -8);

    // data island
    drive(1'b1, 2'b10, 6'd0, 24'd0, {4'b0101, 4'b1111, 4'b0000});
    step();
    idle();
    check_eq("di_lat1", bus_if.out_valid, 1'b0);
    step();
    check_eq("di_valid", bus_if.out_valid, 1'b1);
    check_eq("di_sym", bus_if.out_sym, {10'b0100011110, 10'b1011000011, 10'b1010011100});
    check_eq("di_disp", bus_if.disparity, 15'd0);

    // reset with two words in flight
    drive(1'b1, 2'b01, 6'd0, 24'd0, 12'd0);
    step();
    step();
    check_eq("pre_rst_cnt0", cnt_of(0), -8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    check_eq("mid_rst_valid", bus_if.out_valid, 1'b0);
    check_eq("mid_rst_sym", bus_if.out_sym, {3{10'b1101010100}});
    check_eq("mid_rst_disp", bus_if.disparity, 15'd0);
    step();
    check_eq("flush_valid", bus_if.out_valid, 1'b0);
    check_eq("flush_sym", bus_if.out_sym, {3{10'b1101010100}});
    drive(1'b1, 2'b01, 6'd0, 24'd0, 12'd0);
    step();
    idle();
    check_eq("post_rst_lat1", bus_if.out_valid, 1'b0);
    step();
    check_eq("post_rst_valid", bus_if.out_valid, 1'b1);
    check_eq("post_rst_sym0", sym(0), 10'b0100000000);
    check_eq("post_rst_cnt0", cnt_of(0), -8);

    // random video with bubbles, checked by decoding and symbol disparity
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NUM_CH; k++) cnt_m[k] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc < 596 && $urandom_range(0, 3) != 0) begin
        logic [23:0] v;
        v = 24'($urandom_range(0, 32'h00FF_FFFF));
        drive(1'b1, 2'b01, 6'd0, v, 12'd0);
        exp_q.push_back(v);
      end else begin
        idle();
      end
      step();
      if (bus_if.out_valid) score();
    end
    check_eq("rand_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tmds_encoder_multi.md
TMDS_ENCODER_MULTI -- requirements
Module: tmds_encoder_multi

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent TMDS channels encoded in parallel; legal range 1..4.
REQ-002 Parameter DISP_W, default 5: width of the signed per-channel running-disparity register; legal range 5..8.
REQ-003 Signal clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-004 Signal rst, input, 1 bit: synchronous active-high reset.
REQ-005 Signal in_valid, input, 1 bit: the current input word is to be encoded.
REQ-006 Signal mode, input, 2 bits: 00 control, 01 video data, 10 data island (TERC4), 11 video guard band.
REQ-007 Signal ctrl, input, 2*NUM_CH bits: per-channel control pair {C1,C0}; channel k uses bits [2k+1:2k].
REQ-008 Signal video, input, 8*NUM_CH bits: per-channel pixel byte; channel k uses bits [8k+7:8k].
REQ-009 Signal terc4, input, 4*NUM_CH bits: per-channel TERC4 nibble; channel k uses bits [4k+3:4k].
REQ-010 Signal out_valid, output, 1 bit: out_sym holds a newly encoded word.
REQ-011 Signal out_sym, output, 10*NUM_CH bits: per-channel 10-bit TMDS symbol; channel k uses bits [10k+9:10k].
REQ-012 Signal disparity, output, DISP_W*NUM_CH bits: per-channel signed running disparity, two's complement, for debug.

Function
REQ-013 Pipeline latency SHALL be exactly 2 cycles, in_valid to out_valid; full throughput, one word per cycle.
REQ-014 Stage 1 SHALL register mode, ctrl, terc4, in_valid, the 9-bit q_m per channel, and N1(q_m[7:0]).
REQ-015 q_m selection: if N1(D)>4, or N1(D)==4 and D[0]==0, use the XNOR chain with q_m[8]=0; otherwise use the XOR chain with q_m[8]=1.
REQ-016 Stage 2, video mode, no-bias branch: when cnt==0 or N1==N0 on q_m[7:0], out = {~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}.
REQ-017 In the no-bias branch, cnt SHALL increase by N0-N1 when q_m[8]==0, else by N1-N0.
REQ-018 Stage 2, video mode, invert branch: when (cnt>0 and N1>N0) or (cnt<0 and N0>N1), out = {1, q_m[8], ~q_m[7:0]}.
REQ-019 In the invert branch, cnt SHALL increase by 2*q_m[8]+(N0-N1).
REQ-020 Stage 2, video mode, otherwise: out = {0, q_m[8], q_m[7:0]}.
REQ-021 In the otherwise branch, cnt SHALL increase by (N1-N0)-2*(~q_m[8]).
REQ-022 Disparity arithmetic SHALL be signed, DISP_W bits, with no saturation; a legal video stream keeps |cnt| <= 10.
REQ-023 Control-mode token mapping: 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011.
REQ-024 Data-island mode SHALL map each nibble through the HDMI 1.4 TERC4 table, e.g. 0000->1010011100 and 1111->1011000011.
REQ-025 Guard-band mode: channel k even -> 1011001100; channel k odd -> 0100110011.
REQ-026 Control, data-island and guard-band modes SHALL clear that channel's cnt to 0 in the cycle the word leaves stage 2.
REQ-027 Bubble (in_valid=0 at stage 2): out_sym holds its previous value, cnt is unchanged, and out_valid=0.
REQ-028 Channels SHALL be fully independent; each channel has its own cnt and its own q_m decision.
REQ-029 A mode change between consecutive valid words SHALL take effect on that exact word, with no extra latency and no dropped word.

Reset
REQ-030 While rst=1 at a clock edge: out_valid=0, all stage-1 valid bits 0, all cnt=0.
REQ-031 While rst=1 at a clock edge: every channel of out_sym = 1101010100 (control 00).
REQ-032 Reset asserted mid-stream SHALL discard both in-flight words; the first output after release appears 2 cycles after the first in_valid=1.

Verification
REQ-033 Reset, then video 0x00 on ch0 for 2 consecutive cycles -> out_sym ch0 = 0100000000, cnt=-8, then 1111111111, cnt=+2.
REQ-034 Video 0x00 x2, then one control word ctrl=01 -> ch0 = 0010101011, cnt=0; the next video 0x00 again gives 0100000000.
REQ-035 NUM_CH=3, mode=11 -> {ch2,ch1,ch0} = 1011001100, 0100110011, 1011001100; cnt unchanged on return to video only because it was cleared to 0.
REQ-036 Data island terc4 ch0=0000, ch1=1111 -> 1010011100 and 1011000011; out_valid exactly 2 cycles after in_valid.
REQ-037 Random valid video for 10^5 cycles with random bubbles -> decoded bytes match inputs and |cnt| <= 10 throughout.
REQ-038 rst pulsed while 2 words are in flight -> no out_valid from those words; out_sym = 1101010100 on all channels.
